aes_key_expand: RTL

//  Consumer end of the 128-bit key interface. Latches key_in on the one-cycle key_en strobe.

---
 rtl/aes_pkg.sv | 60 ++++++
 rtl/aes_key_expand_if.sv | 34 +++
 rtl/aes_sbox.sv | 11 +
 rtl/aes_key_expand.sv | 134 +++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants and helpers: key geometry, round constants and the S-box table
// used by both the key schedule and the SubBytes datapath.
package aes_pkg;

    localparam int unsigned NR     = 10;
    localparam int unsigned KEY_W  = 128;
    localparam int unsigned NUM_RK = NR + 1;

    typedef enum logic [0:0] {
        StIdle,
        StExpand
    } ke_state_e;

    // Row-major FIPS-197 S-box; entry 0x00 sits in the top byte.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox_lut(input logic [7:0] a);
        return SBOX_TBL[{~a, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_lut(w[31:24]), sbox_lut(w[23:16]), sbox_lut(w[15:8]), sbox_lut(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        logic [7:0] r;
        case (rnd)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/aes_key_expand_if.sv
// Key load and round-key read port between the key source / round datapath and the
// key expander.
interface aes_key_expand_if;
    import aes_pkg::*;

    logic             key_en;
    logic [KEY_W-1:0] key_in;
    logic [3:0]       rk_sel;
    logic [KEY_W-1:0] rk_out;
    logic             busy;
    logic             key_ready;
    logic             done;

    modport master (
        output key_en,
        output key_in,
        output rk_sel,
        input  rk_out,
        input  busy,
        input  key_ready,
        input  done
    );

    modport slave (
        input  key_en,
        input  key_in,
        input  rk_sel,
        output rk_out,
        output busy,
        output key_ready,
        output done
    );

endinterface

// File: rtl/aes_sbox.sv
// Combinational 8-bit AES S-box lookup.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);

    assign out_o = sbox_lut(in_i);

endmodule

// File: rtl/aes_key_expand.sv
// AES-128 key schedule: latches a key on key_en, derives one round key per clock into an
// 11-entry store, and serves round keys by index.
module aes_key_expand #(
    parameter int unsigned NR       = 10,
    parameter bit          READ_REG = 1'b1
) (
    input logic             sclk,
    input logic             rst_n,
    aes_key_expand_if.slave key_if
);
    import aes_pkg::*;

    localparam int unsigned NumRk = NR + 1;

    if (NR != 10) begin : gen_nr_unsupported
        $error("aes_key_expand: only NR=10 (AES-128) is supported");
    end

    ke_state_e        state_q, state_d;
    logic [3:0]       ctr_q, ctr_d;
    logic             busy_q, busy_d;
    logic             key_ready_q, key_ready_d;
    logic             done_q, done_d;
    logic [KEY_W-1:0] rk_q [NumRk];
    logic [KEY_W-1:0] rk_d [NumRk];

    logic [KEY_W-1:0] rk_prev;
    logic [KEY_W-1:0] rk_next;
    logic [KEY_W-1:0] rd_val;
    logic [31:0]      rot_w;
    logic [31:0]      sub_w;
    logic [31:0]      t_w;
    logic [31:0]      w0_n, w1_n, w2_n, w3_n;

    // Round n derives from entry n-1; ctr outside 1..NR only occurs while the result is unused.
    always_comb begin
        rk_prev = '0;
        for (int unsigned i = 0; i < NumRk; i++) begin
            if (ctr_q == 4'(i + 1)) rk_prev = rk_q[i];
        end
    end

    assign rot_w = {rk_prev[23:0], rk_prev[31:24]};

    for (genvar b = 0; b < 4; b++) begin : gen_sbox
        aes_sbox u_sbox (
            .in_i  (rot_w[8*b +: 8]),
            .out_o (sub_w[8*b +: 8])
        );
    end

    assign t_w     = sub_w ^ {rcon(ctr_q), 24'h0};
    assign w0_n    = rk_prev[127:96] ^ t_w;
    assign w1_n    = rk_prev[95:64] ^ w0_n;
    assign w2_n    = rk_prev[63:32] ^ w1_n;
    assign w3_n    = rk_prev[31:0] ^ w2_n;
    assign rk_next = {w0_n, w1_n, w2_n, w3_n};

    always_comb begin
        state_d     = state_q;
        ctr_d       = ctr_q;
        busy_d      = busy_q;
        key_ready_d = key_ready_q;
        done_d      = 1'b0;
        rk_d        = rk_q;

        // A new key always wins, aborting any run in progress without a done pulse.
        if (key_if.key_en) begin
            rk_d[0]     = key_if.key_in;
            ctr_d       = 4'd1;
            busy_d      = 1'b1;
            key_ready_d = 1'b0;
            state_d     = StExpand;
        end else if (state_q == StExpand) begin
            for (int unsigned i = 1; i < NumRk; i++) begin
                if (ctr_q == 4'(i)) rk_d[i] = rk_next;
            end
            ctr_d = ctr_q + 4'd1;
            if (ctr_q == 4'(NR)) begin
                busy_d      = 1'b0;
                key_ready_d = 1'b1;
                done_d      = 1'b1;
                state_d     = StIdle;
            end
        end
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            ctr_q       <= 4'd0;
            busy_q      <= 1'b0;
            key_ready_q <= 1'b0;
            done_q      <= 1'b0;
            for (int unsigned i = 0; i < NumRk; i++) rk_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            ctr_q       <= ctr_d;
            busy_q      <= busy_d;
            key_ready_q <= key_ready_d;
            done_q      <= done_d;
            rk_q        <= rk_d;
        end
    end

    // Indices past NR read as zero.
    always_comb begin
        rd_val = '0;
        for (int unsigned i = 0; i < NumRk; i++) begin
            if (key_if.rk_sel == 4'(i)) rd_val = rk_q[i];
        end
    end

    if (READ_REG) begin : gen_rd_reg
        logic [KEY_W-1:0] rk_out_q;

        always_ff @(posedge sclk or negedge rst_n) begin
            if (!rst_n) begin
                rk_out_q <= '0;
            end else begin
                rk_out_q <= rd_val;
            end
        end

        assign key_if.rk_out = rk_out_q;
    end else begin : gen_rd_comb
        assign key_if.rk_out = rd_val;
    end

    assign key_if.busy      = busy_q;
    assign key_if.key_ready = key_ready_q;
    assign key_if.done      = done_q;

endmodule
